// File: rtl/seg_mux_if.sv
// Bus bundle for the multiplexed seven-segment driver.
// The master drives the display data and control; the slave (the driver) returns the pin values.
interface seg_mux_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    enable;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] bcd_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    blank_lz;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_done;

  modport master (
    output enable, load, bcd_in, dp_in, blank_lz,
    input  seg, dp, an, frame_done
  );

  modport slave (
    input  enable, load, bcd_in, dp_in, blank_lz,
    output seg, dp, an, frame_done
  );
endinterface

// File: rtl/seg_mux_driver.sv
// Time-multiplexed seven-segment driver: scans NUM_DIGITS digits, holding each for
// PRESCALE clocks, with double-buffered digit data so a new value only appears at
// a frame boundary, optional leading-zero blanking and optional pin inversion.
module seg_mux_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 1000,
  parameter bit HEX_EN     = 1'b1,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input logic      clk,
  input logic      rst_n,
  seg_mux_if.slave bus
);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = $clog2(PRESCALE);
  localparam int BW = 4 * NUM_DIGITS;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [PW-1:0] LAST_PRE = PW'(PRESCALE - 1);

  logic [PW-1:0]         r_presc;
  logic [IW-1:0]         r_idx;
  logic                  r_frame_done;
  logic [BW-1:0]         r_pend_bcd;
  logic [NUM_DIGITS-1:0] r_pend_dp;
  logic                  r_pend_flag;
  logic [BW-1:0]         r_disp_bcd;
  logic [NUM_DIGITS-1:0] r_disp_dp;
  logic [6:0]            r_seg;
  logic                  r_dp;
  logic [NUM_DIGITS-1:0] r_an;

  logic                  w_tick;
  logic                  w_wrap;
  logic [NUM_DIGITS-1:0] w_blank_mask;
  logic [NUM_DIGITS-1:0] w_an;
  logic [3:0]            w_code;
  logic                  w_blank;
  logic                  w_dp;

  // Code-to-segment table, active-high {a,b,c,d,e,f,g}; hex glyphs only when enabled.
  function automatic logic [6:0] f_decode(input logic [3:0] code);
    case (code)
      4'h0:    f_decode = 7'b1111110;
      4'h1:    f_decode = 7'b0110000;
      4'h2:    f_decode = 7'b1101101;
      4'h3:    f_decode = 7'b1111001;
      4'h4:    f_decode = 7'b0110011;
      4'h5:    f_decode = 7'b1011011;
      4'h6:    f_decode = 7'b1011111;
      4'h7:    f_decode = 7'b1110000;
      4'h8:    f_decode = 7'b1111111;
      4'h9:    f_decode = 7'b1111011;
      4'hA:    f_decode = HEX_EN ? 7'b1110111 : 7'b0000000;
      4'hB:    f_decode = HEX_EN ? 7'b0011111 : 7'b0000000;
      4'hC:    f_decode = HEX_EN ? 7'b1001110 : 7'b0000000;
      4'hD:    f_decode = HEX_EN ? 7'b0111101 : 7'b0000000;
      4'hE:    f_decode = HEX_EN ? 7'b1001111 : 7'b0000000;
      default: f_decode = HEX_EN ? 7'b1000111 : 7'b0000000;
    endcase
  endfunction

  // The last prescale count of the last digit is the frame wrap point.
  assign w_tick = bus.enable && (r_presc == LAST_PRE);
  assign w_wrap = w_tick && (r_idx == LAST_IDX);

  // Blank a digit when it and every digit above it are zero; digit 0 always stays lit.
  always_comb begin
    logic v_run;
    v_run        = 1'b1;
    w_blank_mask = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      v_run           = v_run && (r_disp_bcd[4*k +: 4] == 4'd0);
      w_blank_mask[k] = v_run && bus.blank_lz;
    end
  end

  // Select the code, blank flag, dp bit and anode for the current digit index.
  always_comb begin
    w_code  = 4'd0;
    w_blank = 1'b0;
    w_dp    = 1'b0;
    w_an    = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_idx == IW'(k)) begin
        w_code  = r_disp_bcd[4*k +: 4];
        w_blank = w_blank_mask[k];
        w_dp    = r_disp_dp[k];
        w_an[k] = 1'b1;
      end
    end
  end

  // Scan timing: prescaler, digit index and the end-of-frame pulse; all frozen while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc      <= '0;
      r_idx        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_wrap;
      if (bus.enable) begin
        if (w_tick) begin
          r_presc <= '0;
          r_idx   <= w_wrap ? '0 : r_idx + 1'b1;
        end else begin
          r_presc <= r_presc + 1'b1;
        end
      end
    end
  end

  // Double buffer: load lands in pending; display takes it at the frame wrap (or next cycle when idle).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_bcd  <= '0;
      r_pend_dp   <= '0;
      r_pend_flag <= 1'b0;
      r_disp_bcd  <= '0;
      r_disp_dp   <= '0;
    end else begin
      if (bus.load) begin
        r_pend_bcd <= bus.bcd_in;
        r_pend_dp  <= bus.dp_in;
      end
      if (w_wrap && bus.load) begin
        // A load on the wrap cycle bypasses pending so the newest value wins.
        r_disp_bcd  <= bus.bcd_in;
        r_disp_dp   <= bus.dp_in;
        r_pend_flag <= 1'b0;
      end else if (r_pend_flag && (w_wrap || !bus.enable)) begin
        r_disp_bcd  <= r_pend_bcd;
        r_disp_dp   <= r_pend_dp;
        r_pend_flag <= bus.load;
      end else if (bus.load) begin
        r_pend_flag <= 1'b1;
      end
    end
  end

  // Registered pins, one cycle behind the digit index; dark while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg <= '0;
      r_dp  <= 1'b0;
      r_an  <= '0;
    end else if (!bus.enable) begin
      r_seg <= '0;
      r_dp  <= 1'b0;
      r_an  <= '0;
    end else begin
      r_seg <= w_blank ? 7'b0000000 : f_decode(w_code);
      r_dp  <= w_dp;
      r_an  <= w_an;
    end
  end

  // Polarity is applied only at the pins so internal state stays active-high.
  assign bus.seg        = r_seg ^ {7{ACTIVE_LOW}};
  assign bus.dp         = r_dp ^ ACTIVE_LOW;
  assign bus.an         = r_an ^ {NUM_DIGITS{ACTIVE_LOW}};
  assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_seg_mux_driver.sv
// Directed bench for seg_mux_driver: decode sweep on single-digit instances, then scan,
// blanking, tear-free update, enable and reset behaviour on an active-high and an
// active-low four-digit instance sharing the same stimulus.
module tb_seg_mux_driver;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seg_mux_if #(.NUM_DIGITS(4)) if_main ();
  seg_mux_if #(.NUM_DIGITS(4)) if_al ();
  seg_mux_if #(.NUM_DIGITS(1)) if_hex ();
  seg_mux_if #(.NUM_DIGITS(1)) if_nh ();

  assign if_al.enable   = if_main.enable;
  assign if_al.load     = if_main.load;
  assign if_al.bcd_in   = if_main.bcd_in;
  assign if_al.dp_in    = if_main.dp_in;
  assign if_al.blank_lz = if_main.blank_lz;
  assign if_nh.enable   = if_hex.enable;
  assign if_nh.load     = if_hex.load;
  assign if_nh.bcd_in   = if_hex.bcd_in;
  assign if_nh.dp_in    = if_hex.dp_in;
  assign if_nh.blank_lz = if_hex.blank_lz;

  seg_mux_driver #(.NUM_DIGITS(4), .PRESCALE(4), .HEX_EN(1'b1), .ACTIVE_LOW(1'b0))
    dut_main (.clk(clk), .rst_n(rst_n), .bus(if_main));
  seg_mux_driver #(.NUM_DIGITS(4), .PRESCALE(4), .HEX_EN(1'b1), .ACTIVE_LOW(1'b1))
    dut_al (.clk(clk), .rst_n(rst_n), .bus(if_al));
  seg_mux_driver #(.NUM_DIGITS(1), .PRESCALE(2), .HEX_EN(1'b1), .ACTIVE_LOW(1'b0))
    dut_hex (.clk(clk), .rst_n(rst_n), .bus(if_hex));
  seg_mux_driver #(.NUM_DIGITS(1), .PRESCALE(2), .HEX_EN(1'b0), .ACTIVE_LOW(1'b0))
    dut_nh (.clk(clk), .rst_n(rst_n), .bus(if_nh));

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       tag;
    logic [12:0] exp;
  } sb_t;
  sb_t sb_q[$];

  // Reference glyph table, active-high {a..g}.
  function automatic logic [6:0] dec7(input logic [3:0] code, input bit hex);
    case (code)
      4'd0:  return 7'b1111110;
      4'd1:  return 7'b0110000;
      4'd2:  return 7'b1101101;
      4'd3:  return 7'b1111001;
      4'd4:  return 7'b0110011;
      4'd5:  return 7'b1011011;
      4'd6:  return 7'b1011111;
      4'd7:  return 7'b1110000;
      4'd8:  return 7'b1111111;
      4'd9:  return 7'b1111011;
      4'd10: return hex ? 7'b1110111 : 7'b0000000;
      4'd11: return hex ? 7'b0011111 : 7'b0000000;
      4'd12: return hex ? 7'b1001110 : 7'b0000000;
      4'd13: return hex ? 7'b0111101 : 7'b0000000;
      4'd14: return hex ? 7'b1001111 : 7'b0000000;
      default: return hex ? 7'b1000111 : 7'b0000000;
    endcase
  endfunction

  // Expected {frame_done, dp, an, seg} of the active-high 4-digit instance showing digit k.
  function automatic logic [12:0] exp_vec(input logic [15:0] bcd, input logic [3:0] dpv,
                                          input bit blank, input int k, input bit fd);
    logic [15:0] upper;
    logic [3:0]  nib;
    logic [6:0]  seg;
    logic [3:0]  an;
    upper = bcd >> (4 * k);
    nib   = upper[3:0];
    seg   = (blank && k != 0 && upper == 16'd0) ? 7'b0000000 : dec7(nib, 1'b1);
    an    = 4'b0001 << k;
    return {fd, dpv[k], an, seg};
  endfunction

  function automatic logic [12:0] inv_vec(input logic [12:0] v);
    return {v[12], ~v[11:0]};
  endfunction

  function automatic logic [12:0] main_obs();
    return {if_main.frame_done, if_main.dp, if_main.an, if_main.seg};
  endfunction

  function automatic logic [12:0] al_obs();
    return {if_al.frame_done, if_al.dp, if_al.an, if_al.seg};
  endfunction

  task automatic push(input string tag, input logic [12:0] e);
    sb_t s;
    s.tag = tag;
    s.exp = e;
    sb_q.push_back(s);
  endtask

  task automatic pop_check(input logic [12:0] obs);
    sb_t s;
    tests++;
    if (sb_q.size() == 0) begin
      fails++;
      $error("FAIL sb_empty: observed %h required a queued expectation", obs);
      return;
    end
    s = sb_q.pop_front();
    assert (obs === s.exp) begin
      $display("[TB] %s obs=%h exp=%h ok", s.tag, obs, s.exp);
    end else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", s.tag, obs, s.exp);
    end
  endtask

  // Wait (bounded) for a frame_done pulse on the active-high instance.
  task automatic wait_frame(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (if_main.frame_done !== 1'b1 && n < 100);
    tests++;
    assert (if_main.frame_done === 1'b1) else begin
      fails++;
      $error("FAIL %s_frame_wait: frame_done %b expected 1 within 100 cycles", tag, if_main.frame_done);
    end
  endtask

  // Starting right after a frame_done sample, check the 16 cycles of one full frame.
  task automatic frame(input string tag, input logic [15:0] bcd, input logic [3:0] dpv, input bit blank);
    logic [12:0] e;
    for (int c = 1; c <= 16; c++) begin
      e = exp_vec(bcd, dpv, blank, (c - 1) / 4, (c == 16));
      push($sformatf("%s_c%0d_main", tag, c), e);
      push($sformatf("%s_c%0d_al", tag, c), inv_vec(e));
    end
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      pop_check(main_obs());
      pop_check(al_obs());
    end
  endtask

  task automatic load_and_frame(input string tag, input logic [15:0] bcd, input logic [3:0] dpv,
                                input bit blank);
    @(negedge clk);
    if_main.blank_lz = blank;
    if_main.bcd_in   = bcd;
    if_main.dp_in    = dpv;
    if_main.load     = 1'b1;
    @(negedge clk);
    if_main.load = 1'b0;
    wait_frame(tag);
    frame(tag, bcd, dpv, blank);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [12:0] e;
    rst_n            = 1'b0;
    if_main.enable   = 1'b1;
    if_main.load     = 1'b0;
    if_main.bcd_in   = '0;
    if_main.dp_in    = '0;
    if_main.blank_lz = 1'b0;
    if_hex.enable    = 1'b1;
    if_hex.load      = 1'b0;
    if_hex.bcd_in    = '0;
    if_hex.dp_in     = '0;
    if_hex.blank_lz  = 1'b0;

    // Reset state: pins inactive, frame_done low.
    repeat (2) @(negedge clk);
    push("rst_main", 13'h0000);
    push("rst_al", 13'h0FFF);
    push("rst_hex", 13'h0000);
    pop_check(main_obs());
    pop_check(al_obs());
    pop_check({4'b0, if_hex.an, if_hex.dp, if_hex.seg});

    // Release with enable high: digit 0 selected by the second rising edge.
    rst_n = 1'b1;
    e = exp_vec(16'h0000, 4'h0, 1'b0, 0, 1'b0);
    push("release_main", e);
    push("release_al", inv_vec(e));
    repeat (2) @(negedge clk);
    pop_check(main_obs());
    pop_check(al_obs());

    // Decode sweep on single-digit instances, hex and non-hex.
    for (int code = 0; code < 16; code++) begin
      logic [3:0] c4;
      c4 = 4'(code);
      @(negedge clk);
      if_hex.bcd_in = c4;
      if_hex.dp_in  = c4[0];
      if_hex.load   = 1'b1;
      push($sformatf("dec_hex_%0d", code), {4'b0, 1'b1, c4[0], dec7(c4, 1'b1)});
      push($sformatf("dec_nohex_%0d", code), {4'b0, 1'b1, c4[0], dec7(c4, 1'b0)});
      @(negedge clk);
      if_hex.load = 1'b0;
      repeat (3) @(negedge clk);
      pop_check({4'b0, if_hex.an, if_hex.dp, if_hex.seg});
      pop_check({4'b0, if_nh.an, if_nh.dp, if_nh.seg});
    end

    // Leading-zero blanking; dp survives on a blanked digit.
    load_and_frame("blank70", 16'h0070, 4'b0101, 1'b1);
    load_and_frame("blank00", 16'h0000, 4'b0000, 1'b1);

    // Plain scan of 1234.
    load_and_frame("scan1234", 16'h1234, 4'b0000, 1'b0);

    // Tear-free update: loads at index 1 and 2 show only from the next frame.
    wait_frame("tear");
    fork
      frame("tear_old", 16'h1234, 4'h0, 1'b0);
      begin
        repeat (5) @(negedge clk);
        if_main.bcd_in = 16'h1234;
        if_main.load   = 1'b1;
        @(negedge clk);
        if_main.load = 1'b0;
        repeat (3) @(negedge clk);
        if_main.bcd_in = 16'h5678;
        if_main.load   = 1'b1;
        @(negedge clk);
        if_main.load = 1'b0;
      end
    join
    frame("tear_new", 16'h5678, 4'h0, 1'b0);

    // Enable drop at index 2, load while idle, resume at index 2 with the new data.
    wait_frame("enable");
    repeat (9) @(negedge clk);
    if_main.enable = 1'b0;
    for (int c = 10; c <= 14; c++) begin
      push($sformatf("dark_c%0d_main", c), 13'h0000);
      push($sformatf("dark_c%0d_al", c), 13'h0FFF);
    end
    for (int c = 10; c <= 14; c++) begin
      @(negedge clk);
      pop_check(main_obs());
      pop_check(al_obs());
      if (c == 11) begin
        if_main.bcd_in = 16'h4321;
        if_main.load   = 1'b1;
      end
      if (c == 12) if_main.load = 1'b0;
    end
    if_main.enable = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      e = exp_vec(16'h4321, 4'h0, 1'b0, (c < 4) ? 2 : 3, 1'b0);
      push($sformatf("resume_c%0d_main", c), e);
      push($sformatf("resume_c%0d_al", c), inv_vec(e));
    end
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      pop_check(main_obs());
      pop_check(al_obs());
    end

    // Reset mid-frame during a load: outputs go inactive at once, state is discarded.
    @(negedge clk);
    #2;
    if_main.bcd_in = 16'h9999;
    if_main.load   = 1'b1;
    #1;
    rst_n = 1'b0;
    push("midrst_main", 13'h0000);
    push("midrst_al", 13'h0FFF);
    #1;
    pop_check(main_obs());
    pop_check(al_obs());
    @(negedge clk);
    if_main.load = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_frame("post_rst");
    frame("post_rst", 16'h0000, 4'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
